// File: rtl/writeback_stage.sv
// Writeback stage: M/W pipeline register, result select and syscall service (print_int,
// print_char, exit) over a valid/ready byte port. Define WB_PRINT_HEX_EN to add v0=34 print_hex.
module writeback_stage #(
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned REG_ADDR_W    = 5,
    parameter int unsigned V0_PRINT_INT  = 1,
    parameter int unsigned V0_EXIT       = 10,
    parameter int unsigned V0_PRINT_CHAR = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWriteM,
    input  logic                  MemtoRegM,
    input  logic [DATA_W-1:0]     ReadDataM,
    input  logic [DATA_W-1:0]     ALUOutM,
    input  logic [REG_ADDR_W-1:0] WriteRegM,
    input  logic                  syscallM,
    input  logic [DATA_W-1:0]     v0M,
    input  logic [DATA_W-1:0]     a0M,
    output logic                  RegWriteW,
    output logic [REG_ADDR_W-1:0] WriteRegW,
    output logic [DATA_W-1:0]     ResultW,
    output logic                  StallW_out,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  halt
);

`ifdef WB_PRINT_HEX_EN
    localparam int unsigned V0_PRINT_HEX = 34;
`endif

    typedef enum logic [2:0] {StIdle, StConv, StEmit, StDone, StHalt} state_e;

    // W pipeline register
    logic                  regwrite_q, memtoreg_q, syscall_q;
    logic [DATA_W-1:0]     readdata_q, aluout_q, v0_q, a0_q;
    logic [REG_ADDR_W-1:0] writereg_q;

    // Syscall engine state
    state_e                state_q, state_d;
    logic [DATA_W-1:0]     mag_q, mag_d;
    logic [3:0]            digit_q [10];
    logic [3:0]            digit_d [10];
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            pre_q, pre_d;
    logic                  raw_q, raw_d;
    logic                  hex_q, hex_d;
    logic                  clr_sys;

    logic [DATA_W-1:0]     mag_abs, mag_div;
    logic [3:0]            mag_mod, emit_idx, emit_digit;

    assign mag_abs    = a0_q[DATA_W-1] ? (~a0_q + 32'd1) : a0_q;
    assign mag_div    = mag_q / 32'd10;
    assign mag_mod    = 4'(mag_q % 32'd10);
    assign emit_idx   = cnt_q - 4'd1;
    assign emit_digit = digit_q[emit_idx];

    assign StallW_out = (state_q != StIdle) | syscall_q;
    assign RegWriteW  = regwrite_q & ~syscall_q;
    assign WriteRegW  = writereg_q;
    assign ResultW    = memtoreg_q ? readdata_q : aluout_q;
    assign halt       = (state_q == StHalt);

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            readdata_q <= '0;
            aluout_q   <= '0;
            writereg_q <= '0;
            syscall_q  <= 1'b0;
            v0_q       <= '0;
            a0_q       <= '0;
        end else if (!StallW_out) begin
            regwrite_q <= RegWriteM;
            memtoreg_q <= MemtoRegM;
            readdata_q <= ReadDataM;
            aluout_q   <= ALUOutM;
            writereg_q <= WriteRegM;
            syscall_q  <= syscallM;
            v0_q       <= v0M;
            a0_q       <= a0M;
        end else if (clr_sys) begin
            syscall_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mag_q   <= '0;
            cnt_q   <= '0;
            pre_q   <= '0;
            raw_q   <= 1'b0;
            hex_q   <= 1'b0;
            for (int i = 0; i < 10; i++) digit_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
            pre_q   <= pre_d;
            raw_q   <= raw_d;
            hex_q   <= hex_d;
            for (int i = 0; i < 10; i++) digit_q[i] <= digit_d[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        raw_d      = raw_q;
        hex_d      = hex_q;
        digit_d    = digit_q;
        clr_sys    = 1'b0;
        char_valid = 1'b0;
        char_out   = 8'h00;

        case (state_q)
            StIdle: begin
                if (syscall_q) begin
                    raw_d = 1'b0;
                    hex_d = 1'b0;
                    pre_d = 2'd0;
                    cnt_d = 4'd0;
                    if (v0_q == DATA_W'(V0_PRINT_INT)) begin
                        state_d = StConv;
                        mag_d   = mag_abs;
                        pre_d   = {1'b0, a0_q[DATA_W-1]};
                    end else if (v0_q == DATA_W'(V0_PRINT_CHAR)) begin
                        state_d = StEmit;
                        raw_d   = 1'b1;
                    end else if (v0_q == DATA_W'(V0_EXIT)) begin
                        state_d = StHalt;
`ifdef WB_PRINT_HEX_EN
                    end else if (v0_q == DATA_W'(V0_PRINT_HEX)) begin
                        // Nibbles stored LSB-first so EMIT walks them MSB-first like decimal
                        state_d = StEmit;
                        hex_d   = 1'b1;
                        pre_d   = 2'd2;
                        cnt_d   = 4'd8;
                        for (int i = 0; i < 8; i++) digit_d[i] = a0_q[4*i +: 4];
`endif
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StConv: begin
                digit_d[cnt_q] = mag_mod;
                mag_d          = mag_div;
                cnt_d          = cnt_q + 4'd1;
                if (mag_div == '0) state_d = StEmit;
            end
            StEmit: begin
                char_valid = 1'b1;
                if (raw_q) begin
                    char_out = a0_q[7:0];
                end else if (pre_q != 2'd0) begin
                    char_out = !hex_q ? 8'h2d : (pre_q == 2'd2) ? 8'h30 : 8'h78;
                end else if (emit_digit < 4'd10) begin
                    char_out = 8'h30 + {4'd0, emit_digit};
                end else begin
                    char_out = 8'h57 + {4'd0, emit_digit};
                end
                if (char_ready) begin
                    if (raw_q) begin
                        state_d = StDone;
                    end else if (pre_q != 2'd0) begin
                        pre_d = pre_q - 2'd1;
                    end else if (cnt_q == 4'd1) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StDone: begin
                clr_sys = 1'b1;
                state_d = StIdle;
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: random pass-through traffic and syscalls
// checked against a string-level model of the expected character stream.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteM, MemtoRegM, syscallM;
    logic [31:0] ReadDataM, ALUOutM, v0M, a0M;
    logic [4:0]  WriteRegM;
    logic        RegWriteW, StallW_out, char_valid, char_ready, halt;
    logic [4:0]  WriteRegW;
    logic [31:0] ResultW;
    logic [7:0]  char_out;

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteM  (RegWriteM),
        .MemtoRegM  (MemtoRegM),
        .ReadDataM  (ReadDataM),
        .ALUOutM    (ALUOutM),
        .WriteRegM  (WriteRegM),
        .syscallM   (syscallM),
        .v0M        (v0M),
        .a0M        (a0M),
        .RegWriteW  (RegWriteW),
        .WriteRegW  (WriteRegW),
        .ResultW    (ResultW),
        .StallW_out (StallW_out),
        .char_out   (char_out),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .halt       (halt)
    );

    always #5 clk = ~clk;

    task automatic drive_instr(input logic rw, input logic mtr, input logic [31:0] rd,
                               input logic [31:0] alu, input logic [4:0] wr);
        RegWriteM = rw;
        MemtoRegM = mtr;
        ReadDataM = rd;
        ALUOutM   = alu;
        WriteRegM = wr;
        syscallM  = 1'b0;
        v0M       = $urandom;
        a0M       = $urandom;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (RegWriteW !== 1'b0 || WriteRegW !== 5'd0 || ResultW !== 32'd0 || StallW_out !== 1'b0
            || char_valid !== 1'b0 || char_out !== 8'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL %s: rw=%b wr=%0d res=%h stall=%b cv=%b co=%h halt=%b, want all zero",
                     name, RegWriteW, WriteRegW, ResultW, StallW_out, char_valid, char_out, halt);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        char_ready = 1'b0;
        drive_instr(1'b1, 1'b1, $urandom, $urandom, 5'd9);
        syscallM = 1'b1;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_passthrough;
        logic        e_rw, e_mtr;
        logic [31:0] e_rd, e_alu;
        logic [4:0]  e_wr;
        // Bubble left by reset is the first expectation
        e_rw = 0; e_mtr = 0; e_rd = 0; e_alu = 0; e_wr = 0;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (ResultW !== (e_mtr ? e_rd : e_alu) || WriteRegW !== e_wr || RegWriteW !== e_rw
                || StallW_out !== 1'b0) begin
                errors++;
                $display("FAIL passthrough[%0d]: res=%h wr=%0d rw=%b stall=%b, want %h %0d %b 0",
                         i, ResultW, WriteRegW, RegWriteW, StallW_out,
                         e_mtr ? e_rd : e_alu, e_wr, e_rw);
            end
            if (i == 0) begin
                e_rw = 1; e_mtr = 1; e_rd = 32'hDEADBEEF; e_alu = 32'h10; e_wr = 5'd8;
            end else begin
                e_rw = 1'($urandom); e_mtr = 1'($urandom); e_rd = $urandom; e_alu = $urandom;
                e_wr = 5'($urandom);
            end
            drive_instr(e_rw, e_mtr, e_rd, e_alu, e_wr);
            @(negedge clk);
        end
    endtask

    // rmode: 0 ready high, 1 toggling, 2 random
    task automatic test_syscall(input logic [31:0] v0, input logic [31:0] a0, input int rmode,
                                input string name);
        string       exp, got;
        int          exp_stall, n;
        bit          done, hold, r;
        logic [7:0]  hold_ch;
        logic        f_rw, f_mtr;
        logic [31:0] f_rd, f_alu;
        logic [4:0]  f_wr;
        exp = ""; got = ""; exp_stall = -1;
        if (v0 == 32'd1) exp = $sformatf("%0d", $signed(a0));
        else if (v0 == 32'd11) exp = $sformatf("%c", a0[7:0]);
`ifdef WB_PRINT_HEX_EN
        else if (v0 == 32'd34) exp = $sformatf("0x%08h", a0);
`endif
        else exp_stall = 2;

        drive_instr(1'b1, 1'($urandom), $urandom, $urandom, 5'($urandom));
        syscallM = 1'b1; v0M = v0; a0M = a0;
        @(negedge clk);
        checks++;
        if (StallW_out !== 1'b1 || RegWriteW !== 1'b0) begin
            errors++;
            $display("FAIL %s capture: stall=%b rw=%b, want 1 0", name, StallW_out, RegWriteW);
        end
        f_rw = 1'($urandom); f_mtr = 1'($urandom); f_rd = $urandom; f_alu = $urandom;
        f_wr = 5'($urandom);
        drive_instr(f_rw, f_mtr, f_rd, f_alu, f_wr);

        n = 0; done = 0; hold = 0; hold_ch = 0;
        while (!done && n < 400) begin
            if (n > 0) @(negedge clk);
            n++;
            if (!StallW_out) begin
                done = 1;
            end else begin
                r = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(n) : 1'($urandom);
                char_ready = r;
                if (hold) begin
                    checks++;
                    if (char_valid !== 1'b1 || char_out !== hold_ch) begin
                        errors++;
                        $display("FAIL %s hold: cv=%b co=%h, want 1 %h", name, char_valid,
                                 char_out, hold_ch);
                    end
                end
                if (char_valid === 1'b1 && r) got = $sformatf("%s%c", got, char_out);
                hold = (char_valid === 1'b1) && !r;
                hold_ch = char_out;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall still %b after %0d cycles, want 0", name,
                     StallW_out, n);
        end
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s stream: got \"%s\", want \"%s\"", name, got, exp);
        end
        if (exp_stall >= 0) begin
            checks++;
            if (n - 1 != exp_stall) begin
                errors++;
                $display("FAIL %s stall length: %0d cycles, want %0d", name, n - 1, exp_stall);
            end
        end
        @(negedge clk);
        checks++;
        if (ResultW !== (f_mtr ? f_rd : f_alu) || RegWriteW !== f_rw || WriteRegW !== f_wr
            || StallW_out !== 1'b0) begin
            errors++;
            $display("FAIL %s follow-up: res=%h rw=%b wr=%0d stall=%b, want %h %b %0d 0", name,
                     ResultW, RegWriteW, WriteRegW, StallW_out, f_mtr ? f_rd : f_alu, f_rw, f_wr);
        end
    endtask

    task automatic test_halt;
        string got;
        int    n;
        got = "";
        char_ready = 1'b1;
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        syscallM = 1'b1; v0M = 32'd11; a0M = 32'h41;
        @(negedge clk);
        // Exit syscall waits in M behind the print_char
        syscallM = 1'b1; v0M = 32'd10; a0M = $urandom;
        n = 0;
        while (halt !== 1'b1 && n < 50) begin
            if (char_valid === 1'b1) got = $sformatf("%s%c", got, char_out);
            @(negedge clk);
            n++;
        end
        checks++;
        if (got != "A") begin
            errors++;
            $display("FAIL halt stream: got \"%s\", want \"A\"", got);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (halt !== 1'b1 || StallW_out !== 1'b1 || char_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt sticky: halt=%b stall=%b cv=%b, want 1 1 0", halt, StallW_out,
                     char_valid);
        end
        reset = 1'b1;
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs("halt cleared by reset");
    endtask

    task automatic test_reset_mid_emit;
        string got;
        int    n;
        bit    seen;
        got = ""; n = 0;
        char_ready = 1'b1;
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        syscallM = 1'b1; v0M = 32'd1; a0M = 32'd12345;
        @(negedge clk);
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        while (got.len() < 2 && n < 50) begin
            if (char_valid === 1'b1) got = $sformatf("%s%c", got, char_out);
            @(negedge clk);
            n++;
        end
        checks++;
        if (got != "12") begin
            errors++;
            $display("FAIL reset-mid prefix: got \"%s\", want \"12\"", got);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs("reset mid-emit");
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (char_valid !== 1'b0 || StallW_out !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset-mid quiet: activity seen after reset, want none");
        end
    endtask

    task automatic test_random_syscalls;
        logic [31:0] v0, a0;
        int          k;
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 3));
            a0 = $urandom;
            if (i % 4 == 0) a0 = 32'(int'($urandom_range(0, 20)) - 10);
            case (k)
                0:       v0 = 32'd1;
                1:       begin v0 = 32'd11; a0[7:0] = 8'($urandom_range(32, 126)); end
                2:       v0 = 32'd34;
                default: v0 = 32'($urandom_range(12, 33));
            endcase
            test_syscall(v0, a0, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        reset = 1'b1;
        char_ready = 1'b0;
        drive_instr(1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_passthrough();
        test_syscall(32'd1, 32'hFFFF_FECF, 0, "int -305");
        test_syscall(32'd1, 32'h8000_0000, 1, "int min");
        test_syscall(32'd1, 32'd0, 2, "int zero");
        test_syscall(32'd1, 32'h7FFF_FFFF, 2, "int max");
        test_syscall(32'd11, 32'h41, 1, "char A");
        test_syscall(32'd34, 32'hA, 0, "hex 0xa");
        test_syscall(32'd7, 32'd99, 0, "unknown 7");
        test_random_syscalls();
        test_reset_mid_emit();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
